// File: rtl/mic_scan_scheduler.sv
// mic_scan_scheduler: divides the clock down to a scan period, walks the eight
// ADC channels once per period under a snapshotted channel mask, and queues the
// selected {channel, sample} pairs in a 4-deep FIFO for a ready/valid consumer.
// Samples arriving while the FIFO is full are dropped and counted.
module mic_scan_scheduler #(
  parameter int unsigned SAMPLE_DIV = 1250
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [7:0]  CH_MASK,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic [11:0] OUT_DATA,
  output logic [2:0]  OUT_CHAN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        BUSY,
  output logic [7:0]  OVERFLOW_CNT
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  // Drop counter saturates instead of wrapping so a long stall stays visible.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [15:0] div_cnt;
  logic        tick;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  ptr;
  logic [2:0]  ptr_nxt;
  logic [7:0]  snap;
  logic [7:0]  snap_nxt;

  logic [11:0] ch_sel;
  logic        wr_vld_p0;
  logic [14:0] wr_ent_p0;

  logic [14:0] ent     [4];
  logic [14:0] ent_nxt [4];
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic [2:0]  wpos;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;

  assign tick = ENABLE && (div_cnt == DIV_LAST);

  // Scan-period divider; parked at zero whenever ENABLE is low.
  always_ff @(posedge CLOCK) begin
    if (RESET || !ENABLE) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Scan FSM state, channel pointer, mask snapshot and registered BUSY.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= '0;
      snap  <= '0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      snap  <= snap_nxt;
      BUSY  <= (state_nxt == SCAN);
    end
  end

  // Next-state logic: a tick with a non-empty mask starts an 8-cycle sweep.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    snap_nxt  = snap;
    case (state)
      IDLE: begin
        if (tick && (CH_MASK != 8'h00)) begin
          state_nxt = SCAN;
          snap_nxt  = CH_MASK;
          ptr_nxt   = 3'd0;
        end
      end
      SCAN: begin
        if (ptr == 3'd7) begin
          state_nxt = IDLE;
          ptr_nxt   = 3'd0;
        end else begin
          ptr_nxt = ptr + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = 3'd0;
      end
    endcase
  end

  // Channel multiplexer addressed by the scan pointer.
  always_comb begin
    ch_sel = CH0;
    case (ptr)
      3'd1:    ch_sel = CH1;
      3'd2:    ch_sel = CH2;
      3'd3:    ch_sel = CH3;
      3'd4:    ch_sel = CH4;
      3'd5:    ch_sel = CH5;
      3'd6:    ch_sel = CH6;
      3'd7:    ch_sel = CH7;
      default: ch_sel = CH0;
    endcase
  end

  // ---- stage p0: FIFO write request for the channel under the pointer ----
  assign wr_vld_p0 = (state == SCAN) && snap[ptr];
  assign wr_ent_p0 = {ptr, ch_sel};

  assign full = (cnt == 3'd4);
  assign pop  = OUT_VALID && OUT_READY;
  assign push = wr_vld_p0 && (!full || pop);
  assign drop = wr_vld_p0 && full && !pop;
  assign wpos = cnt - {2'b00, pop};

  // FIFO next contents: entry 0 is the head, a pop shifts everything down and
  // a push lands just past the last occupied slot after that shift.
  always_comb begin
    if (pop) begin
      ent_nxt[0] = ent[1];
      ent_nxt[1] = ent[2];
      ent_nxt[2] = ent[3];
      ent_nxt[3] = '0;
    end else begin
      ent_nxt[0] = ent[0];
      ent_nxt[1] = ent[1];
      ent_nxt[2] = ent[2];
      ent_nxt[3] = ent[3];
    end
    if (push) begin
      ent_nxt[wpos[1:0]] = wr_ent_p0;
    end
    cnt_nxt = cnt + {2'b00, push} - {2'b00, pop};
  end

  // ---- stage p1: FIFO storage, head register, valid flag, drop counter ----
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        ent[i] <= '0;
      end
      cnt          <= '0;
      OUT_VALID    <= 1'b0;
      OVERFLOW_CNT <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ent[i] <= ent_nxt[i];
      end
      cnt       <= cnt_nxt;
      OUT_VALID <= (cnt_nxt != 3'd0);
      if (drop) begin
        OVERFLOW_CNT <= sat_inc(OVERFLOW_CNT);
      end
    end
  end

  assign OUT_DATA = ent[0][11:0];
  assign OUT_CHAN = ent[0][14:12];

endmodule

// File: tb/tb_mic_scan_scheduler.sv
// Bench for mic_scan_scheduler: directed scenarios followed by a random run,
// all checked against a transaction-level model built on a sample queue.
module tb_mic_scan_scheduler;

  localparam int DIV = 16;

  logic        CLOCK;
  logic        rst;
  logic        en;
  logic [7:0]  mask;
  logic        rdy;
  logic [11:0] OUT_DATA;
  logic [2:0]  OUT_CHAN;
  logic        OUT_VALID;
  logic        BUSY;
  logic [7:0]  OVERFLOW_CNT;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [14:0] m_q[$];
  int          m_div;
  int          m_scan;
  logic [7:0]  m_snap;
  int          m_ovf;

  // samples seen leaving the FIFO
  logic [14:0] got[$];

  mic_scan_scheduler #(.SAMPLE_DIV(DIV)) dut (
    .CLOCK(CLOCK),
    .RESET(rst),
    .ENABLE(en),
    .CH_MASK(mask),
    .CH0(12'h100), .CH1(12'h101), .CH2(12'h102), .CH3(12'h103),
    .CH4(12'h104), .CH5(12'h105), .CH6(12'h106), .CH7(12'h107),
    .OUT_DATA(OUT_DATA),
    .OUT_CHAN(OUT_CHAN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(rdy),
    .BUSY(BUSY),
    .OVERFLOW_CNT(OVERFLOW_CNT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT sampled.
  task automatic model_edge();
    bit          wr;
    bit          tk;
    logic [14:0] w;
    if (rst) begin
      m_q.delete();
      m_div  = 0;
      m_scan = -1;
      m_snap = 8'h00;
      m_ovf  = 0;
      return;
    end
    wr = 1'b0;
    w  = '0;
    if (m_scan >= 0) begin
      wr = m_snap[m_scan];
      w  = {3'(m_scan), 12'h100 + 12'(m_scan)};
    end
    tk = en && (m_div == DIV - 1);
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (wr) begin
      if (m_q.size() < 4) m_q.push_back(w);
      else if (m_ovf < 255) m_ovf++;
    end
    if (m_scan >= 0) m_scan = (m_scan == 7) ? -1 : m_scan + 1;
    else if (tk && mask != 8'h00) begin
      m_scan = 0;
      m_snap = mask;
    end
    m_div = !en ? 0 : (tk ? 0 : m_div + 1);
  endtask

  task automatic compare_model();
    check("model_busy", 32'(BUSY), 32'(m_scan >= 0));
    check("model_valid", 32'(OUT_VALID), 32'(m_q.size() != 0));
    check("model_ovf", 32'(OVERFLOW_CNT), 32'(m_ovf));
    if (m_q.size() != 0) begin
      check("model_chan", 32'(OUT_CHAN), 32'(m_q[0][14:12]));
      check("model_data", 32'(OUT_DATA), 32'(m_q[0][11:0]));
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    model_edge();
    #1;
    compare_model();
    if (OUT_VALID === 1'b1 && rdy === 1'b1) got.push_back({OUT_CHAN, OUT_DATA});
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_busy(input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (BUSY === 1'b1) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int cyc;
    int n;
    int exp_a5[4];
    exp_a5 = '{0, 2, 5, 7};
    rst  = 1'b1;
    en   = 1'b0;
    mask = 8'h00;
    rdy  = 1'b1;

    // reset state
    step();
    step();
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ovf", 32'(OVERFLOW_CNT), 32'd0);
    check("rst_data", 32'(OUT_DATA), 32'd0);
    check("rst_chan", 32'(OUT_CHAN), 32'd0);

    // first scan timing with a single channel
    rst  = 1'b0;
    en   = 1'b1;
    mask = 8'h01;
    for (int c = 0; c < 26; c++) begin
      step();
      cyc = c + 1;
      check("lat_busy", 32'(BUSY), 32'(cyc >= 16 && cyc <= 23));
      check("lat_valid", 32'(OUT_VALID), 32'(cyc == 17));
      if (cyc == 17) begin
        check("lat_data", 32'(OUT_DATA), 32'h100);
        check("lat_chan", 32'(OUT_CHAN), 32'd0);
      end
    end

    // sparse mask: two scans, channels 0,2,5,7 in order
    do_reset();
    en   = 1'b1;
    mask = 8'hA5;
    rdy  = 1'b1;
    got.delete();
    for (int c = 0; c < 46; c++) step();
    check("a5_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size() && i < 8; i++) begin
      check("a5_chan", 32'(got[i][14:12]), 32'(exp_a5[i % 4]));
      check("a5_data", 32'(got[i][11:0]), 32'h100 + 32'(exp_a5[i % 4]));
    end

    // full mask with a stalled consumer: four kept, four dropped
    do_reset();
    en   = 1'b1;
    mask = 8'hFF;
    rdy  = 1'b0;
    for (int c = 0; c < 24; c++) step();
    check("ovf_first", 32'(OVERFLOW_CNT), 32'd4);
    check("ovf_valid", 32'(OUT_VALID), 32'd1);
    check("ovf_head_chan", 32'(OUT_CHAN), 32'd0);
    check("ovf_head_data", 32'(OUT_DATA), 32'h100);

    // pop in the same cycle as a write into the full FIFO
    wait_busy("full_pop_busy_seen", n);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check("full_pop_chan", 32'(OUT_CHAN), 32'd1);
    check("full_pop_data", 32'(OUT_DATA), 32'h101);
    check("full_pop_ovf", 32'(OVERFLOW_CNT), 32'd4);
    check("full_pop_valid", 32'(OUT_VALID), 32'd1);

    // many more stalled scans saturate the drop counter
    for (int c = 0; c < 64 * DIV; c++) step();
    check("ovf_sat", 32'(OVERFLOW_CNT), 32'd255);
    check("ovf_sat_head", 32'(OUT_CHAN), 32'd1);
    check("ovf_sat_data", 32'(OUT_DATA), 32'h101);

    // empty mask: no scans, no samples
    do_reset();
    en   = 1'b1;
    mask = 8'h00;
    rdy  = 1'b1;
    for (int c = 0; c < 3 * DIV; c++) begin
      step();
      check("nomask_busy", 32'(BUSY), 32'd0);
      check("nomask_valid", 32'(OUT_VALID), 32'd0);
    end

    // mask change mid-scan does not affect the running scan
    mask = 8'hFF;
    got.delete();
    wait_busy("midmask_busy_seen", n);
    step();
    step();
    mask = 8'h01;
    for (int c = 0; c < 12; c++) step();
    check("midmask_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size() && i < 8; i++) begin
      check("midmask_chan", 32'(got[i][14:12]), 32'(i));
    end

    // reset at pointer 3 aborts the scan
    do_reset();
    en   = 1'b1;
    mask = 8'hFF;
    rdy  = 1'b0;
    wait_busy("abort_busy_seen", n);
    step();
    step();
    step();
    check("abort_pre_valid", 32'(OUT_VALID), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", 32'(OUT_VALID), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_data", 32'(OUT_DATA), 32'd0);
    check("abort_chan", 32'(OUT_CHAN), 32'd0);
    check("abort_ovf", 32'(OVERFLOW_CNT), 32'd0);
    en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      check("abort_after_valid", 32'(OUT_VALID), 32'd0);
      check("abort_after_busy", 32'(BUSY), 32'd0);
    end

    // ENABLE dropped mid-scan: scan completes, divider restarts from zero
    rdy = 1'b1;
    en  = 1'b1;
    got.delete();
    wait_busy("en_busy_seen", n);
    check("en_first_delay", 32'(n), 32'd16);
    step();
    step();
    en = 1'b0;
    for (int c = 0; c < 12; c++) step();
    check("en_scan_count", 32'(got.size()), 32'd8);
    check("en_idle_busy", 32'(BUSY), 32'd0);
    en = 1'b1;
    wait_busy("en_again_seen", n);
    check("en_restart_delay", 32'(n), 32'd16);

    // random traffic against the model
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 31) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      if ($urandom_range(0, 63) == 0) mask = 8'h00;
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mic_scan_scheduler.md
MIC_SCAN_SCHEDULER -- requirements
Module: mic_scan_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1250, meaning CLOCK cycles per scan period (50 MHz -> 40 kHz); legal range 9..65535.
REQ-002 SHALL have port CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ENABLE  input  1  runs the scan-period divider when high.
REQ-005 SHALL have port CH_MASK  input  8  channel-select mask; bit k selects CHk.
REQ-006 SHALL have ports CH0..CH7  input  12 each  live conversion results from the ADC controller.
REQ-007 SHALL have port OUT_DATA  output  12  sample at the FIFO head.
REQ-008 SHALL have port OUT_CHAN  output  3  channel index of the FIFO-head sample.
REQ-009 SHALL have port OUT_VALID  output  1  FIFO not empty.
REQ-010 SHALL have port OUT_READY  input  1  consumer accepts the head sample.
REQ-011 SHALL have port BUSY  output  1  high while the FSM is in SCAN.
REQ-012 SHALL have port OVERFLOW_CNT  output  8  count of dropped samples, saturating.

Function
REQ-013 Divider SHALL count 0..SAMPLE_DIV-1 while ENABLE=1, wrap to 0, and assert internal tick for the single cycle in which count = SAMPLE_DIV-1.
REQ-014 ENABLE=0 SHALL hold the divider at 0 and suppress tick; a scan in progress SHALL complete; FIFO contents SHALL be retained.
REQ-015 FSM states SHALL be IDLE and SCAN only; IDLE->SCAN on tick when CH_MASK != 0, with CH_MASK snapshotted and pointer set to 0 at that edge.
REQ-016 Tick with CH_MASK = 0 SHALL leave the FSM in IDLE with no FIFO write.
REQ-017 In SCAN, pointer SHALL step 0..7, one channel per cycle; SCAN SHALL last exactly 8 cycles; SCAN->IDLE at the edge ending pointer = 7.
REQ-018 In each SCAN cycle with the snapshot bit for the pointer set, {pointer, CH[pointer]} SHALL be written to the FIFO at that cycle's ending edge; unselected channels SHALL produce no write.
REQ-019 Mask changes during SCAN SHALL have no effect until the next scan.
REQ-020 FIFO SHALL be 4 entries, first-in first-out; OUT_DATA/OUT_CHAN SHALL be registered from the head entry and stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 Pop SHALL occur at an edge where OUT_VALID=1 and OUT_READY=1; OUT_READY while empty SHALL have no effect.
REQ-022 Write when full with no simultaneous pop SHALL drop the new sample, keep FIFO contents, and increment OVERFLOW_CNT, saturating at 255.
REQ-023 Simultaneous write and pop when full SHALL accept both, with no drop and occupancy unchanged.
REQ-024 Latency: first SCAN cycle (pointer 0) SHALL be the cycle after tick; a write into an empty FIFO SHALL raise OUT_VALID in the following cycle.
REQ-025 BUSY SHALL equal (state = SCAN), registered.

Reset
REQ-026 RESET=1 at an edge SHALL force state IDLE, pointer 0, divider 0, FIFO empty, mask snapshot 0, OUT_VALID 0, OUT_DATA 0, OUT_CHAN 0, BUSY 0, OVERFLOW_CNT 0; RESET overrides all other inputs.
REQ-027 RESET asserted mid-SCAN SHALL abort the scan; no further writes from that scan SHALL occur.

Verification (bench SAMPLE_DIV=16, CHk = 12'h100+k, OUT_READY=1 unless stated)
REQ-028 ENABLE rises at cycle 0, CH_MASK=8'h01 -> tick at cycle 15, BUSY high cycles 16-23, OUT_VALID high at cycle 17, OUT_DATA=12'h100, OUT_CHAN=0.
REQ-029 CH_MASK=8'hA5 -> per scan, exactly 4 samples in order chan 0,2,5,7 with data 12'h100,12'h102,12'h105,12'h107.
REQ-030 CH_MASK=8'hFF, OUT_READY=0 -> FIFO holds chan 0-3, OVERFLOW_CNT=4 after first scan; after 64 scans it saturates at 255; head stays chan 0.
REQ-031 FIFO full, OUT_READY pulsed 1 in the same cycle as a write -> head advances, new sample accepted, OVERFLOW_CNT unchanged.
REQ-032 CH_MASK=8'h00 for 3 periods -> BUSY and OUT_VALID stay 0; mask changed 8'hFF->8'h01 at pointer 2 -> still 8 samples that scan.
REQ-033 RESET pulsed during SCAN at pointer 3 (mask 8'hFF), FIFO partly filled -> next cycle all outputs 0, FIFO empty, no further writes; ENABLE deasserted mid-scan -> scan completes, divider held at 0.
